// File: rtl/wf_window_ctrl.sv
// ---------------------------------------------------------------------------
// wf_window_ctrl
//
// Window-limits controller for the waveform display. Three buttons drive a
// display-mode / zoom-level state machine. The four window bounds come out of
// that state. Each bound moves toward its target by at most SLEW px per
// cycle, which animates resizing.
//
// Ports:
//   clk              system clock
//   rst              asynchronous, active-low reset
//   btn_mode         mode button (level, debounced, synchronous)
//   btn_in           zoom-in / step-back button (level)
//   btn_out          zoom-out button (level)
//   start_x, end_x   current left / right bound
//   start_y, end_y   current top / bottom bound
//   mode             0=DEFAULT, 1=MAX_WIDTH, 2=FULL, 3=MAX_HEIGHT
//   zoom             current zoom level (0..N_ZOOM)
//   busy             high while any bound differs from its target
// ---------------------------------------------------------------------------
module wf_window_ctrl #(
    parameter int COORD_W = 10,
    parameter int N_ZOOM  = 4,
    parameter int DEF_SX  = 138,
    parameter int DEF_EX  = 838,
    parameter int DEF_SY  = 62,
    parameter int DEF_EY  = 482,
    parameter int MAX_SX  = 88,
    parameter int MAX_EX  = 888,
    parameter int MAX_SY  = 32,
    parameter int MAX_EY  = 512,
    parameter int STEP_X  = 10,
    parameter int STEP_Y  = 6,
    parameter int SLEW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_mode,
    input  logic               btn_in,
    input  logic               btn_out,
    output logic [COORD_W-1:0] start_x,
    output logic [COORD_W-1:0] end_x,
    output logic [COORD_W-1:0] start_y,
    output logic [COORD_W-1:0] end_y,
    output logic [1:0]         mode,
    output logic [3:0]         zoom,
    output logic               busy
);

    typedef enum logic [1:0] {
        MODE_DEFAULT    = 2'd0,
        MODE_MAX_WIDTH  = 2'd1,
        MODE_FULL       = 2'd2,
        MODE_MAX_HEIGHT = 2'd3
    } mode_t;

    localparam logic [COORD_W-1:0] DSX    = COORD_W'(DEF_SX);
    localparam logic [COORD_W-1:0] DEX    = COORD_W'(DEF_EX);
    localparam logic [COORD_W-1:0] DSY    = COORD_W'(DEF_SY);
    localparam logic [COORD_W-1:0] DEY    = COORD_W'(DEF_EY);
    localparam logic [COORD_W-1:0] MSX    = COORD_W'(MAX_SX);
    localparam logic [COORD_W-1:0] MEX    = COORD_W'(MAX_EX);
    localparam logic [COORD_W-1:0] MSY    = COORD_W'(MAX_SY);
    localparam logic [COORD_W-1:0] MEY    = COORD_W'(MAX_EY);
    localparam logic [COORD_W-1:0] STEP_XC = COORD_W'(STEP_X);
    localparam logic [COORD_W-1:0] STEP_YC = COORD_W'(STEP_Y);
    localparam logic [COORD_W-1:0] SLEW_C  = COORD_W'(SLEW);
    localparam logic [3:0]         ZMAX    = 4'(N_ZOOM);

    mode_t              mode_q;
    logic [3:0]         zoom_q;
    logic [2:0]         btn_q;
    logic [2:0]         btn_now;
    logic [2:0]         edges;
    logic               p_mode, p_in, p_out;
    logic [COORD_W-1:0] sx_q, ex_q, sy_q, ey_q;
    logic [COORD_W-1:0] tsx, tex, tsy, tey;
    logic [COORD_W-1:0] off_x, off_y;

    // A press is accepted only when exactly one button has a rising edge in
    // this cycle. Simultaneous edges cancel each other.
    assign btn_now = {btn_mode, btn_in, btn_out};
    assign edges   = btn_now & ~btn_q;
    assign p_mode  = (edges == 3'b100);
    assign p_in    = (edges == 3'b010);
    assign p_out   = (edges == 3'b001);

    // Mode / zoom state machine. The button history resets to 1, so a button
    // held through reset does not register as a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= MODE_DEFAULT;
            zoom_q <= '0;
            btn_q  <= '1;
        end else begin
            btn_q <= btn_now;
            case (mode_q)
                MODE_DEFAULT: begin
                    if (p_mode) begin
                        if (zoom_q == 4'd0) mode_q <= MODE_MAX_WIDTH;
                        zoom_q <= '0;
                    end else if (p_in) begin
                        if (zoom_q < ZMAX) begin
                            zoom_q <= zoom_q + 4'd1;
                        end else begin
                            mode_q <= MODE_FULL;
                            zoom_q <= '0;
                        end
                    end else if (p_out) begin
                        if (zoom_q != 4'd0) zoom_q <= zoom_q - 4'd1;
                    end
                end
                MODE_MAX_WIDTH: begin
                    if (p_mode)    mode_q <= MODE_FULL;
                    else if (p_in) mode_q <= MODE_DEFAULT;
                end
                MODE_FULL: begin
                    if (p_mode)    mode_q <= MODE_MAX_HEIGHT;
                    else if (p_in) mode_q <= MODE_MAX_WIDTH;
                end
                default: begin
                    if (p_mode)    mode_q <= MODE_DEFAULT;
                    else if (p_in) mode_q <= MODE_FULL;
                end
            endcase
        end
    end

    // Target bounds come straight from the state registers. In DEFAULT mode
    // each zoom level widens the window symmetrically.
    always_comb begin
        off_x = COORD_W'(zoom_q) * STEP_XC;
        off_y = COORD_W'(zoom_q) * STEP_YC;
        tsx = DSX;
        tex = DEX;
        tsy = DSY;
        tey = DEY;
        case (mode_q)
            MODE_DEFAULT: begin
                tsx = DSX - off_x;
                tex = DEX + off_x;
                tsy = DSY - off_y;
                tey = DEY + off_y;
            end
            MODE_MAX_WIDTH: begin
                tsx = MSX;
                tex = MEX;
            end
            MODE_FULL: begin
                tsx = MSX;
                tex = MEX;
                tsy = MSY;
                tey = MEY;
            end
            default: begin
                tsy = MSY;
                tey = MEY;
            end
        endcase
    end

    // One slew step toward the target. The distance is computed in the
    // direction of travel first, so the unsigned arithmetic never wraps and
    // the bound never overshoots.
    function automatic logic [COORD_W-1:0] slew_step(
        input logic [COORD_W-1:0] cur,
        input logic [COORD_W-1:0] tgt
    );
        logic [COORD_W-1:0] diff;
        logic [COORD_W-1:0] step;
        if (cur < tgt) begin
            diff = tgt - cur;
            step = (diff > SLEW_C) ? SLEW_C : diff;
            return cur + step;
        end else begin
            diff = cur - tgt;
            step = (diff > SLEW_C) ? SLEW_C : diff;
            return cur - step;
        end
    endfunction

    // Bounds registers. Reset snaps them to the defaults without slewing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sx_q <= DSX;
            ex_q <= DEX;
            sy_q <= DSY;
            ey_q <= DEY;
        end else begin
            sx_q <= slew_step(sx_q, tsx);
            ex_q <= slew_step(ex_q, tex);
            sy_q <= slew_step(sy_q, tsy);
            ey_q <= slew_step(ey_q, tey);
        end
    end

    assign start_x = sx_q;
    assign end_x   = ex_q;
    assign start_y = sy_q;
    assign end_y   = ey_q;
    assign mode    = mode_q;
    assign zoom    = zoom_q;
    assign busy    = (sx_q != tsx) || (ex_q != tex) || (sy_q != tsy) || (ey_q != tey);

endmodule

// File: tb/tb_wf_window_ctrl.sv
// Testbench for wf_window_ctrl: table-driven button presses plus hand-written
// sequences for settle timing, simultaneous presses, mid-slew redirection and
// asynchronous reset.
module tb_wf_window_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_in;
    logic       btn_out;
    logic [9:0] start_x, end_x, start_y, end_y;
    logic [1:0] mode;
    logic [3:0] zoom;
    logic       busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       b_mode;
        logic       b_in;
        logic       b_out;
        logic [1:0] exp_mode;
        logic [3:0] exp_zoom;
        int         sx;
        int         ex;
        int         sy;
        int         ey;
    } vec_t;

    vec_t vecs[16];

    wf_window_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_in   (btn_in),
        .btn_out  (btn_out),
        .start_x  (start_x),
        .end_x    (end_x),
        .start_y  (start_y),
        .end_y    (end_y),
        .mode     (mode),
        .zoom     (zoom),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one value and records the result.
    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Pulses the requested buttons for one cycle, then waits (bounded) for
    // the bounds to settle.
    task automatic applyStimulus(input logic m, input logic i, input logic o);
        int n;
        @(negedge clk);
        btn_mode = m;
        btn_in   = i;
        btn_out  = o;
        @(negedge clk);
        btn_mode = 1'b0;
        btn_in   = 1'b0;
        btn_out  = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("settle_timeout", 1, 0);
    endtask

    // Compares the full settled state against one table entry.
    task automatic checkOutput(input int idx, input vec_t v);
        check($sformatf("vec%0d_mode", idx), int'(mode), int'(v.exp_mode));
        check($sformatf("vec%0d_zoom", idx), int'(zoom), int'(v.exp_zoom));
        check($sformatf("vec%0d_sx", idx), int'(start_x), v.sx);
        check($sformatf("vec%0d_ex", idx), int'(end_x), v.ex);
        check($sformatf("vec%0d_sy", idx), int'(start_y), v.sy);
        check($sformatf("vec%0d_ey", idx), int'(end_y), v.ey);
        check($sformatf("vec%0d_busy", idx), int'(busy), 0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 2'd0, 4'd1, 128, 848, 56, 488};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 4'd2, 118, 858, 50, 494};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'd0, 4'd3, 108, 868, 44, 500};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'd0, 4'd4,  98, 878, 38, 506};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'd2, 4'd0,  88, 888, 32, 512};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'd1, 4'd0,  88, 888, 62, 482};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 138, 838, 62, 482};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 2'd1, 4'd0,  88, 888, 62, 482};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'd1, 4'd0,  88, 888, 62, 482};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'd2, 4'd0,  88, 888, 32, 512};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 2'd3, 4'd0, 138, 838, 32, 512};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 138, 838, 62, 482};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 138, 838, 62, 482};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 2'd0, 4'd1, 128, 848, 56, 488};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 138, 838, 62, 482};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 138, 838, 62, 482};

        // Reset with btn_in held: releasing reset must not produce a press.
        rst      = 1'b0;
        btn_mode = 1'b0;
        btn_in   = 1'b1;
        btn_out  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_mode", int'(mode), 0);
        check("reset_zoom", int'(zoom), 0);
        check("reset_sx", int'(start_x), 138);
        check("reset_ex", int'(end_x), 838);
        check("reset_sy", int'(start_y), 62);
        check("reset_ey", int'(end_y), 482);
        check("reset_busy", int'(busy), 0);
        btn_in = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 16; k++) begin
            applyStimulus(vecs[k].b_mode, vecs[k].b_in, vecs[k].b_out);
            checkOutput(k, vecs[k]);
        end

        // Zoom level 1 settle timing: start_x 138 -> 134 -> 130 -> 128.
        @(negedge clk);
        btn_in = 1'b1;
        @(negedge clk);
        btn_in = 1'b0;
        check("settle_zoom", int'(zoom), 1);
        check("settle_sx0", int'(start_x), 138);
        check("settle_busy0", int'(busy), 1);
        @(negedge clk);
        check("settle_sx1", int'(start_x), 134);
        @(negedge clk);
        check("settle_sx2", int'(start_x), 130);
        check("settle_busy2", int'(busy), 1);
        @(negedge clk);
        check("settle_sx3", int'(start_x), 128);
        check("settle_ey3", int'(end_y), 488);
        check("settle_busy3", int'(busy), 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        check("restore_zoom", int'(zoom), 0);

        // Simultaneous in+out edges: nothing happens, busy stays low.
        @(negedge clk);
        btn_in  = 1'b1;
        btn_out = 1'b1;
        @(negedge clk);
        check("simul_zoom", int'(zoom), 0);
        check("simul_mode", int'(mode), 0);
        check("simul_busy", int'(busy), 0);
        btn_in  = 1'b0;
        btn_out = 1'b0;
        @(negedge clk);
        check("simul_sx", int'(start_x), 138);

        // Mid-slew redirection: in, then out one cycle later.
        @(negedge clk);
        btn_in = 1'b1;
        @(negedge clk);
        check("redir_zoom1", int'(zoom), 1);
        check("redir_sx0", int'(start_x), 138);
        btn_out = 1'b1;
        @(negedge clk);
        check("redir_zoom0", int'(zoom), 0);
        check("redir_sx1", int'(start_x), 134);
        check("redir_busy1", int'(busy), 1);
        @(negedge clk);
        check("redir_sx2", int'(start_x), 138);
        check("redir_busy2", int'(busy), 0);
        btn_in  = 1'b0;
        btn_out = 1'b0;
        @(negedge clk);
        check("redir_sx3", int'(start_x), 138);

        // Asynchronous reset in the middle of a slew toward MAX_WIDTH.
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        check("areset_mode_pre", int'(mode), 1);
        @(negedge clk);
        check("areset_sx_pre", int'(start_x), 134);
        #2;
        rst = 1'b0;
        #1;
        check("areset_sx", int'(start_x), 138);
        check("areset_ex", int'(end_x), 838);
        check("areset_sy", int'(start_y), 62);
        check("areset_ey", int'(end_y), 482);
        check("areset_mode", int'(mode), 0);
        check("areset_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_sx", int'(start_x), 138);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wf_window_ctrl.md
Name: wf_window_ctrl

Overview:
- Parametrised successor to the waveform display window-limits controller.
- Holds a display-mode / zoom-level state machine driven by three buttons and emits the four waveform window bounds.
- Generalises the fixed zoom stages to N_ZOOM levels with configurable steps, adds internal press-edge detection, and slews bounds toward their target at SLEW px/cycle for animated resizing.
- Sits between the button press units and the waveform display/VGA region logic.

Parameters:
- COORD_W, 10: width of all coordinate buses.
- N_ZOOM, 4: number of zoom levels above level 0 (legal range 1..15).
- DEF_SX / DEF_EX / DEF_SY / DEF_EY, 138 / 838 / 62 / 482: default window bounds.
- MAX_SX / MAX_EX / MAX_SY / MAX_EY, 88 / 888 / 32 / 512: maximum window bounds.
- STEP_X, 10: px added to each x-edge per zoom level.
- STEP_Y, 6: px added to each y-edge per zoom level.
- SLEW, 4: maximum px any bound moves per cycle (must be at least 1).
- Legality: DEF_SX-N_ZOOM*STEP_X >= MAX_SX; DEF_EX+N_ZOOM*STEP_X <= MAX_EX; same rule for y.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- btn_mode  in  1  mode button, level; debounced and synchronous.
- btn_in  in  1  zoom-in / back button, level.
- btn_out  in  1  zoom-out button, level.
- start_x  out  COORD_W  current left bound.
- end_x  out  COORD_W  current right bound.
- start_y  out  COORD_W  current top bound.
- end_y  out  COORD_W  current bottom bound.
- mode  out  2  0=DEFAULT, 1=MAX_WIDTH, 2=FULL, 3=MAX_HEIGHT.
- zoom  out  4  current zoom level (0..N_ZOOM).
- busy  out  1  high while any bound differs from its target.

Behaviour:
- Reset (rst=0, async):
  - mode=DEFAULT, zoom=0.
  - Bounds load DEF_* directly, with no slewing.
  - busy=0.
  - Button history registers load 1, so a button held through reset yields no press.
- Press detection: press = btn & ~btn_q, where btn_q is the value from the previous cycle.
  - A press is valid only when exactly one of the three buttons has an edge in that cycle.
  - Two or three simultaneous edges are all discarded.
- State update: mode and zoom change on the same clock edge that samples the valid press.
- Transitions, DEFAULT mode with zoom z:
  - mode press: z=0 → MAX_WIDTH; z>0 → DEFAULT, z=0.
  - in press: z<N_ZOOM → z+1; z=N_ZOOM → FULL, z=0.
  - out press: z>0 → z-1; z=0 → no change.
- Transitions, other modes (z is always 0):
  - mode press steps forward: MAX_WIDTH→FULL→MAX_HEIGHT→DEFAULT.
  - in press steps back: MAX_WIDTH→DEFAULT, FULL→MAX_WIDTH, MAX_HEIGHT→FULL.
  - out press is ignored.
- Targets (combinational from the state registers):
  - DEFAULT: SX=DEF_SX-z*STEP_X, EX=DEF_EX+z*STEP_X, SY=DEF_SY-z*STEP_Y, EY=DEF_EY+z*STEP_Y.
  - MAX_WIDTH: x bounds = MAX_*, y bounds = DEF_*.
  - FULL: all MAX_*.
  - MAX_HEIGHT: x bounds = DEF_*, y bounds = MAX_*.
- Slew:
  - On every clock after the state update, each bound moves toward its target by min(SLEW, |target-bound|).
  - The four bounds move independently and never overshoot.
  - The first bound change appears one cycle after the state change.
  - Arithmetic is unsigned COORD_W, with difference computed before subtraction so there is no wrap.
- busy: high whenever any bound != target, derived from registered outputs. It goes low in the cycle the last bound reaches its target.
- Presses while busy are accepted: the target updates immediately and motion redirects from the current position.
- Holding a button generates only one press. Release, then press again, is required for the next action.
- Reset asserted mid-slew snaps all bounds to DEF_* immediately.

Test Plan:
- Reset release with btn_in held high → no press seen; bounds 138/838/62/482, zoom=0, busy=0.
- btn_in pulse ×4 from DEFAULT, waiting for busy=0 each time → zoom 1..4; final bounds 98/878/38/506. Level 1 takes 3 cycles to settle (10 px at SLEW=4: 4, 4, 2).
- Fifth btn_in pulse → mode=FULL, zoom=0, bounds 88/888/32/512. Then btn_in → MAX_WIDTH (88/888/62/482), then btn_in → DEFAULT.
- btn_mode pulses from DEFAULT → MAX_WIDTH, FULL, MAX_HEIGHT (138/838/32/512), DEFAULT. btn_out in MAX_WIDTH → no change.
- btn_in and btn_out rising in the same cycle → discarded; state and bounds unchanged, busy stays 0.
- btn_in at zoom=0, then btn_out 1 cycle later mid-slew → target returns to default; start_x goes 138→134→138 with no overshoot. Then rst=0 asynchronously mid-slew → immediate 138/838/62/482.
